dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: core load/store path.
  - port 1: debug/testbench access path (memory inspection or preload).
- Round-robin arbitration with an optional lock for multi-beat sequences, bounded by a hold limit.
- Fixed-latency, in-order response return via a tag pipeline.
- Sits between requesters and dmem; dmem itself is unchanged.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin grant with
// bounded lock ownership, plus a fixed-latency tag pipeline for in-order responses.
module dmem_arbiter #(
    parameter int XLEN     = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_valid_i,
    output logic            m0_ready_o,
    input  logic [XLEN-1:0] m0_addr_i,
    input  logic            m0_we_i,
    input  logic [XLEN-1:0] m0_wdata_i,
    input  logic [3:0]      m0_wmask_i,
    input  logic            m0_lock_i,
    output logic            m0_rsp_valid_o,
    output logic [XLEN-1:0] m0_rdata_o,
    input  logic            m1_valid_i,
    output logic            m1_ready_o,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic            m1_we_i,
    input  logic [XLEN-1:0] m1_wdata_i,
    input  logic [3:0]      m1_wmask_i,
    input  logic            m1_lock_i,
    output logic            m1_rsp_valid_o,
    output logic [XLEN-1:0] m1_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

    state_t              r_state, w_state_n;
    logic                r_last, w_last_n;
    logic [HW-1:0]       r_hold, w_hold_n, w_hold_inc;
    logic                w_gnt0, w_gnt1, w_acc, w_lock, w_other_v, w_rsp_vld;
    logic [MEM_LAT-1:0]  r_tag_vld, r_tag_id, r_tag_we;

    // Grants are masked while reset is held so every output reads 0 during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_i) begin
            case (r_state)
                OWN0:    w_gnt0 = m0_valid_i;
                OWN1:    w_gnt1 = m1_valid_i;
                default: begin
                    w_gnt0 = m0_valid_i & (~m1_valid_i | r_last);
                    w_gnt1 = m1_valid_i & (~m0_valid_i | ~r_last);
                end
            endcase
        end
    end

    assign w_acc      = w_gnt0 | w_gnt1;
    assign w_lock     = w_gnt1 ? m1_lock_i  : m0_lock_i;
    assign w_other_v  = w_gnt1 ? m0_valid_i : m1_valid_i;
    assign w_hold_inc = (r_state == ARB)    ? HOLD_ONE :
                        (r_hold == HOLD_MAX) ? HOLD_MAX : r_hold + HOLD_ONE;

    // The beat that brings the locked run to MAX_HOLD releases ownership if the
    // other port is waiting, so the waiter never sees more than MAX_HOLD beats go by.
    always_comb begin
        w_state_n = r_state;
        w_last_n  = r_last;
        w_hold_n  = r_hold;
        if (w_acc) begin
            w_last_n = w_gnt1;
            if (!w_lock || (w_other_v && (w_hold_inc == HOLD_MAX))) begin
                w_state_n = ARB;
                w_hold_n  = '0;
            end else begin
                w_state_n = w_gnt1 ? OWN1 : OWN0;
                w_hold_n  = w_hold_inc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB;
            r_last  <= 1'b1;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_n;
            r_last  <= w_last_n;
            r_hold  <= w_hold_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_tag_we  <= '0;
        end else begin
            r_tag_vld[0] <= w_acc;
            r_tag_id[0]  <= w_gnt1;
            r_tag_we[0]  <= w_acc & (w_gnt1 ? m1_we_i : m0_we_i);
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
                r_tag_we[i]  <= r_tag_we[i-1];
            end
        end
    end

    always_comb begin
        mem_en_o    = w_acc;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (w_gnt0) begin
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_wmask_o = m0_wmask_i;
        end else if (w_gnt1) begin
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_wmask_o = m1_wmask_i;
        end
    end

    assign m0_ready_o     = w_gnt0;
    assign m1_ready_o     = w_gnt1;
    assign w_rsp_vld      = r_tag_vld[MEM_LAT-1];
    assign m0_rsp_valid_o = w_rsp_vld & ~r_tag_id[MEM_LAT-1];
    assign m1_rsp_valid_o = w_rsp_vld &  r_tag_id[MEM_LAT-1];
    assign m0_rdata_o     = (m0_rsp_valid_o && !r_tag_we[MEM_LAT-1]) ? mem_rdata_i : '0;
    assign m1_rdata_o     = (m1_rsp_valid_o && !r_tag_we[MEM_LAT-1]) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3 share stimulus
// and a memory model; both are checked every cycle against a behavioural reference.
module tb_dmem_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v [2];
    logic        we [2];
    logic        lk [2];
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic [3:0]  wm [2];

    logic        rdy0_a, rdy1_a, rv0_a, rv1_a, men_a, mwe_a;
    logic [31:0] rd0_a, rd1_a, maddr_a, mwd_a;
    logic [3:0]  mwm_a;
    logic        rdy0_b, rdy1_b, rv0_b, rv1_b, men_b, mwe_b;
    logic [31:0] rd0_b, rd1_b, maddr_b, mwd_b;
    logic [3:0]  mwm_b;

    logic [31:0] dev_mem [64];
    logic [31:0] rd_pipe [3];
    logic        mem_load;

    dmem_arbiter #(.XLEN(XLEN), .MEM_LAT(1), .MAX_HOLD(MAX_HOLD)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .m0_valid_i(v[0]), .m0_ready_o(rdy0_a), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
        .m0_wdata_i(wd[0]), .m0_wmask_i(wm[0]), .m0_lock_i(lk[0]),
        .m0_rsp_valid_o(rv0_a), .m0_rdata_o(rd0_a),
        .m1_valid_i(v[1]), .m1_ready_o(rdy1_a), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
        .m1_wdata_i(wd[1]), .m1_wmask_i(wm[1]), .m1_lock_i(lk[1]),
        .m1_rsp_valid_o(rv1_a), .m1_rdata_o(rd1_a),
        .mem_en_o(men_a), .mem_we_o(mwe_a), .mem_addr_o(maddr_a), .mem_wdata_o(mwd_a),
        .mem_wmask_o(mwm_a), .mem_rdata_i(rd_pipe[0])
    );

    dmem_arbiter #(.XLEN(XLEN), .MEM_LAT(3), .MAX_HOLD(MAX_HOLD)) u_dut_l3 (
        .clk_i(clk), .rst_i(rst),
        .m0_valid_i(v[0]), .m0_ready_o(rdy0_b), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
        .m0_wdata_i(wd[0]), .m0_wmask_i(wm[0]), .m0_lock_i(lk[0]),
        .m0_rsp_valid_o(rv0_b), .m0_rdata_o(rd0_b),
        .m1_valid_i(v[1]), .m1_ready_o(rdy1_b), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
        .m1_wdata_i(wd[1]), .m1_wmask_i(wm[1]), .m1_lock_i(lk[1]),
        .m1_rsp_valid_o(rv1_b), .m1_rdata_o(rd1_b),
        .mem_en_o(men_b), .mem_we_o(mwe_b), .mem_addr_o(maddr_b), .mem_wdata_o(mwd_b),
        .mem_wmask_o(mwm_b), .mem_rdata_i(rd_pipe[2])
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i) * 32'h0101);
    endfunction

    // Single-port memory driven by the MEM_LAT=1 instance; read data delayed 1 and 3 cycles.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= init_word(i);
        end else if (men_a && mwe_a) begin
            for (int b = 0; b < 4; b++)
                if (mwm_a[b]) dev_mem[maddr_a[7:2]][8*b +: 8] <= mwd_a[8*b +: 8];
        end
        rd_pipe[0] <= (men_a && !mwe_a) ? dev_mem[maddr_a[7:2]] : 32'h0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end

    // Reference model state
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          own, last, beats;
    int          wait_c [2];
    logic [31:0] ref_mem [64];
    logic        ev [2][8];
    int          ep [2][8];
    logic [31:0] ed [2][8];
    int          lat [2] = '{1, 3};

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input logic pv, input logic pwe, input logic [31:0] pa,
                            input logic [31:0] pd, input logic [3:0] pm, input logic pl);
        v[p] = pv; we[p] = pwe; addr[p] = pa; wd[p] = pd; wm[p] = pm; lk[p] = pl;
    endtask

    task automatic model_clear();
        own = -1; last = 1; beats = 0;
        wait_c[0] = 0; wait_c[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 8; s++) ev[i][s] = 1'b0;
    endtask

    // Called one time-step after a rising edge; checks the cycle, advances the model.
    task automatic step();
        int          g, j, s, k;
        logic [5:0]  idx;
        logic [65:0] er;
        logic [1:0]  erdy;
        logic [69:0] em;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s = cyc % 8;
            er = '0;
            if (ev[i][s]) begin
                if (ep[i][s] == 0) begin er[65] = 1'b1; er[63:32] = ed[i][s]; end
                else begin er[64] = 1'b1; er[31:0] = ed[i][s]; end
                ev[i][s] = 1'b0;
            end
            if (i == 0) chk("rsp_lat1", 192'({rv0_a, rv1_a, rd0_a, rd1_a}), 192'(er));
            else        chk("rsp_lat3", 192'({rv0_b, rv1_b, rd0_b, rd1_b}), 192'(er));
        end

        g = -1;
        if (own == 0)                 begin if (v[0]) g = 0; end
        else if (own == 1)            begin if (v[1]) g = 1; end
        else if (v[0] && v[1])        g = (last == 0) ? 1 : 0;
        else if (v[0])                g = 0;
        else if (v[1])                g = 1;

        erdy = {g == 0, g == 1};
        em   = '0;
        if (g >= 0) em = {1'b1, we[g], wm[g], addr[g], wd[g]};
        chk("ready_lat1", 192'({rdy0_a, rdy1_a}), 192'(erdy));
        chk("ready_lat3", 192'({rdy0_b, rdy1_b}), 192'(erdy));
        chk("mem_lat1", 192'({men_a, mwe_a, mwm_a, maddr_a, mwd_a}), 192'(em));
        chk("mem_lat3", 192'({men_b, mwe_b, mwm_b, maddr_b, mwd_b}), 192'(em));

        // Starvation bound measured from the DUT's own grants
        for (int p = 0; p < 2; p++) if (!v[p]) wait_c[p] = 0;
        if (rdy0_a || rdy1_a) begin
            k = rdy1_a ? 1 : 0;
            wait_c[k] = 0;
            if (v[1-k]) wait_c[1-k]++;
            chk("max_wait", 192'(wait_c[1-k] > MAX_HOLD ? wait_c[1-k] : 0), 192'(0));
        end

        if (g >= 0) begin
            j = 1 - g;
            idx = addr[g][7:2];
            last = g;
            if (we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (wm[g][b]) ref_mem[idx][8*b +: 8] = wd[g][8*b +: 8];
            end
            for (int i = 0; i < 2; i++) begin
                s = (cyc + lat[i]) % 8;
                ev[i][s] = 1'b1;
                ep[i][s] = g;
                ed[i][s] = we[g] ? 32'h0 : ref_mem[idx];
            end
            if (!lk[g]) begin
                own = -1; beats = 0;
            end else begin
                beats = (own < 0) ? 1 : ((beats < MAX_HOLD) ? beats + 1 : MAX_HOLD);
                if (v[j] && beats >= MAX_HOLD) begin own = -1; beats = 0; end
                else own = g;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        set_port(1, 1'b1, 1'b1, 32'h14, 32'h55, 4'hF, 1'b0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("rst_outs_lat1", 192'({rdy0_a, rdy1_a, rv0_a, rv1_a, men_a, mwe_a, mwm_a,
                                       rd0_a, rd1_a, maddr_a, mwd_a}), 192'(0));
            chk("rst_outs_lat3", 192'({rdy0_b, rdy1_b, rv0_b, rv1_b, men_b, mwe_b, mwm_b,
                                       rd0_b, rd1_b, maddr_b, mwd_b}), 192'(0));
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (n) step();
    endtask

    initial begin
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_clear();
        rst = 1'b1;
        mem_load = 1'b1;
        @(posedge clk);
        #1;
        mem_load = 1'b0;
        do_reset();

        // Single read of the preloaded word from port 0
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        step();
        idle(3);

        // Round-robin on a tie right after reset
        do_reset();
        for (int n = 0; n < 4; n++) begin
            set_port(0, 1'b1, 1'b0, 32'h10 + 32'(4*n), 32'h0, 4'h0, 1'b0);
            set_port(1, 1'b1, 1'b0, 32'h40 + 32'(4*n), 32'h0, 4'h0, 1'b0);
            step();
        end
        idle(3);

        // Port 1 locks for six beats while port 0 keeps requesting
        for (int n = 0; n < 8; n++) begin
            set_port(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
            set_port(1, 1'b1, 1'b0, 32'h80 + 32'(4*n), 32'h0, 4'h0, (n < 6));
            step();
        end
        idle(3);

        // Partial write from port 0, then read-back from port 1
        set_port(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011, 1'b0);
        step();
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        step();
        idle(4);

        // Reset while a read is in flight, then a fresh tie
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        step();
        do_reset();
        idle(5);
        set_port(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 1'b0);
        step();
        idle(4);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            for (int p = 0; p < 2; p++)
                set_port(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                         $urandom & 32'h8000_00FF, $urandom, 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 1) == 1));
            step();
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
